// File: rtl/pixel_array_readout.sv
// Pixel array model: erase, expose, ramp-convert, then stream rows out on VALID/READY.
// Latency: first row E+2+2^PIXEL_BITS cycles after the accepted START; one row per cycle.
// Backpressure: READY=0 holds ROW/DATA_OUT stable indefinitely; START is ignored outside IDLE.
module pixel_array_readout #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int PIXEL_BITS = 8,
    parameter int EXP_BITS   = 8
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic                                       START,
    input  logic [EXP_BITS-1:0]                        EXPOSE_TIME,
    input  logic [HEIGHT-1:0][WIDTH-1:0][PIXEL_BITS-1:0] LIGHT,
    input  logic                                       READY,
    output logic                                       VALID,
    output logic [$clog2(HEIGHT)-1:0]                  ROW,
    output logic [WIDTH-1:0][PIXEL_BITS-1:0]           DATA_OUT,
    output logic                                       BUSY,
    output logic                                       DONE
);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [RW-1:0]         LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [PIXEL_BITS-1:0] RAMP_MAX = '1;

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} state_t;

    state_t                                     state, state_nxt;
    logic [EXP_BITS-1:0]                        exp_cnt;
    logic [PIXEL_BITS-1:0]                      ramp;
    logic [RW-1:0]                              row_ptr;
    logic                                       done_q;
    logic [HEIGHT-1:0][WIDTH-1:0][PIXEL_BITS-1:0] level, code, level_acc;
    logic [HEIGHT-1:0][WIDTH-1:0]               latched, hit;
    logic                                       last_hs;

    // One extra bit of headroom so an overflowing accumulate clamps instead of wrapping.
    function automatic logic [PIXEL_BITS-1:0] sat_add(input logic [PIXEL_BITS-1:0] a,
                                                      input logic [PIXEL_BITS-1:0] b);
        logic [PIXEL_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PIXEL_BITS] ? RAMP_MAX : s[PIXEL_BITS-1:0];
    endfunction

    always_comb begin
        level_acc = '0;
        hit       = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                level_acc[r][c] = sat_add(level[r][c], LIGHT[r][c]);
                hit[r][c]       = !latched[r][c] && (ramp >= level[r][c]);
            end
        end
    end

    assign last_hs = (state == READ) && READY && (row_ptr == LAST_ROW);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = ERASE;
            ERASE:   state_nxt = (exp_cnt != '0) ? EXPOSE : CONVERT;
            EXPOSE:  if (exp_cnt <= EXP_BITS'(1)) state_nxt = CONVERT;
            CONVERT: if (ramp == RAMP_MAX) state_nxt = READ;
            READ:    if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            level   <= '0;
            code    <= '0;
            latched <= '0;
            ramp    <= '0;
            exp_cnt <= '0;
            row_ptr <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_hs;
            case (state)
                IDLE: if (START) exp_cnt <= EXPOSE_TIME;
                ERASE: begin
                    level   <= '0;
                    code    <= '0;
                    latched <= '0;
                    ramp    <= '0;
                end
                EXPOSE: begin
                    level   <= level_acc;
                    exp_cnt <= exp_cnt - 1'b1;
                end
                CONVERT: begin
                    // Ramp wraps back to 0 after the last step, ready for the next frame.
                    ramp <= ramp + 1'b1;
                    for (int r = 0; r < HEIGHT; r++) begin
                        for (int c = 0; c < WIDTH; c++) begin
                            if (hit[r][c]) begin
                                code[r][c]    <= ramp;
                                latched[r][c] <= 1'b1;
                            end
                        end
                    end
                end
                READ: if (READY) row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
                default: ;
            endcase
        end
    end

    assign VALID    = (state == READ);
    assign ROW      = row_ptr;
    assign DATA_OUT = code[row_ptr];
    assign BUSY     = (state != IDLE);
    assign DONE     = done_q;
endmodule

// File: doc/pixel_array_readout.md
# pixel_array_readout

Parametrised, self-sequenced successor to the fixed-size pixel array. It holds a HEIGHT×WIDTH array of digital pixel models, each with an exposure integrator and a single-slope (ramp) ADC latch. It runs the full erase → expose → convert → read cycle from one START pulse, then streams rows out over a valid/ready handshake. It sits between the sensor-level controller and the row-readout/serialiser logic, and replaces the externally driven ERASE/EXPOSE/READ/COUNTER scheme.

## Interface
Parameters:
- WIDTH, 4, pixels per row (columns); ≥1.
- HEIGHT, 4, rows; ≥2.
- PIXEL_BITS, 8, ADC resolution and pixel level width.
- EXP_BITS, 8, width of the exposure-time input.

Ports:
- CLK  in  1  single clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a frame; honoured in IDLE only.
- EXPOSE_TIME  in  EXP_BITS  exposure length in cycles; sampled on accepted START.
- LIGHT  in  [HEIGHT][WIDTH][PIXEL_BITS]  per-pixel light increment, added once per exposure cycle.
- READY  in  1  downstream accepts the current row.
- VALID  out  1  DATA_OUT/ROW hold a valid row.
- ROW  out  $clog2(HEIGHT)  index of the row on DATA_OUT.
- DATA_OUT  out  [WIDTH][PIXEL_BITS]  converted codes of row ROW, column 0 in element 0.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the last row is accepted.

## Operation
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ.
- **IDLE:** START=1 latches EXPOSE_TIME into an exposure counter, then ERASE next cycle. START in any other state is ignored.
- **ERASE (1 cycle):** all pixel levels and all pixel codes are cleared to 0. Next state is EXPOSE if the latched time is >0; otherwise CONVERT.
- **EXPOSE (latched-time cycles):** each cycle, every pixel's level becomes min(level + LIGHT[r][c], 2^PIXEL_BITS−1). Use a PIXEL_BITS+1-bit add, then saturate; it never wraps. The counter decrements each cycle and the state leaves to CONVERT on the cycle the count reaches 1.
- **CONVERT (exactly 2^PIXEL_BITS cycles):** the ramp counter runs 0, 1, …, 2^PIXEL_BITS−1.
  - Each pixel has a "latched" flag, cleared in ERASE.
  - On the first cycle where ramp ≥ level and latched=0, code ← ramp and latched ← 1.
  - Every pixel latches by the last ramp value, so the final code equals the pixel's level.
  - After ramp = max, go to READ with the row pointer at 0.
- **READ:**
  - VALID=1 and ROW = row pointer; DATA_OUT shows that row's codes combinationally from the code array.
  - On VALID&&READY, the pointer increments.
  - On the handshake of row HEIGHT−1, the pointer wraps to 0, the next state is IDLE, and DONE=1 for that next cycle.
  - READY=0 stalls indefinitely with ROW/DATA_OUT stable.
- Codes persist in IDLE until the next ERASE, but DATA_OUT is meaningful only while VALID=1.
- **RESET** (any state, including mid-EXPOSE/CONVERT/READ): the next state is IDLE. Levels, codes, latched flags, ramp, exposure counter and row pointer all go to 0. No DONE pulse is generated by a reset.

## Timing
- Reset values:
  - VALID=0, BUSY=0, DONE=0, ROW=0, DATA_OUT=0.
  - All internal arrays and counters are 0.
- Let START be sampled high at edge t0 and let E be the latched time.
  - ERASE occupies cycle 1.
  - EXPOSE occupies cycles 2..E+1.
  - CONVERT occupies the next 2^PIXEL_BITS cycles.
  - The first VALID appears in cycle E+2+2^PIXEL_BITS after t0.
  - For E=0 the first VALID appears in cycle 2+2^PIXEL_BITS.
- BUSY rises the cycle after the accepted START. It falls the cycle after the final handshake, coincident with DONE.
- One row per cycle is transferred when READY is held high, so READ lasts HEIGHT cycles minimum.
- START in the DONE cycle (state IDLE) is accepted, so back-to-back frames have no dead cycle beyond DONE.
- A LIGHT change mid-EXPOSE takes effect from the next accumulation cycle. LIGHT is ignored outside EXPOSE.

## Test plan
- **Reset/idle:** apply RESET, then hold START=0 for 10 cycles → VALID=0, BUSY=0, DONE=0, DATA_OUT=0 throughout.
- **Basic frame:** WIDTH=4, HEIGHT=4, PIXEL_BITS=8, LIGHT[r][c]=r*4+c, EXPOSE_TIME=3, READY=1.
  - First VALID arrives 261 cycles after START.
  - Rows 0..3 carry codes 3*(r*4+c).
  - DONE pulses once, the cycle after ROW=3.
- **Saturation:** LIGHT=200 everywhere, EXPOSE_TIME=2 → all codes 255 (no wrap to 144).
- **Zero exposure:** EXPOSE_TIME=0 → ERASE goes straight to CONVERT; first VALID 258 cycles after START; all codes 0.
- **Back-pressure:** READY toggles 0,0,1 repeatedly → each row is held stable for 3 cycles, rows arrive in order 0..3, DONE fires once after the 4th handshake, and START pulses during READ are ignored.
- **Reset mid-operation:** assert RESET during CONVERT (ramp=100), then START a new frame with LIGHT=1, EXPOSE_TIME=5 → IDLE after reset with no DONE; the new frame reads all codes =5.
